// File: rtl/mpi_bus_master_arb.sv
// Two-port round-robin arbiter and BK MPI bus master: runs one read, word write or
// byte write per grant and drives the active-low pad levels and enables.
module mpi_bus_master_arb #(
  parameter int unsigned ADDR_SETUP = 2,
  parameter int unsigned DATA_SETUP = 1,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        CLKp,
  input  logic        RSTp,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        byte0,
  input  logic        byte1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic [15:0] rdata,
  output logic [15:0] nAD_o,
  output logic        nAD_oe,
  input  logic [15:0] nAD_i,
  output logic        nSYNC_o,
  output logic        nSYNC_oe,
  output logic        nDIN_o,
  output logic        nDOUT_o,
  output logic        nWTBT_o,
  output logic        ctrl_oe,
  output logic        nBSY_o,
  input  logic        nRPLY_i
);

  localparam int unsigned PMAX = (ADDR_SETUP > DATA_SETUP) ? ADDR_SETUP : DATA_SETUP;
  localparam int unsigned PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = '1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_SYNC, S_DSET, S_STRB, S_RWAIT, S_REND, S_SREL, S_DONE
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          rply_q;
  logic          gnt, gnt_d;
  logic          cur_we, we_d;
  logic          cur_byte, byte_d;
  logic [15:0]   cur_addr, addr_d;
  logic [15:0]   cur_wdata, wdata_d;
  logic          rr_ptr, rr_d;
  logic          err_flag, errf_d;
  logic [15:0]   rdata_d;
  logic [15:0]   nad_d;
  logic          nad_oe_d, nsync_d, nsync_oe_d, ndin_d, ndout_d, nwtbt_d;
  logic          ctrl_oe_d, nbsy_d, ack0_d, ack1_d, err_d;

  // Next-state and next pad/handshake values; outputs reflect the state being entered
  always_comb begin
    state_d    = state;
    pcnt_d     = pcnt;
    tcnt_d     = tcnt;
    gnt_d      = gnt;
    we_d       = cur_we;
    byte_d     = cur_byte;
    addr_d     = cur_addr;
    wdata_d    = cur_wdata;
    rr_d       = rr_ptr;
    errf_d     = err_flag;
    rdata_d    = rdata;
    nad_d      = 16'hFFFF;
    nad_oe_d   = 1'b0;
    nsync_d    = 1'b1;
    nsync_oe_d = 1'b0;
    ndin_d     = 1'b1;
    ndout_d    = 1'b1;
    nwtbt_d    = 1'b1;
    ctrl_oe_d  = 1'b0;
    nbsy_d     = 1'b1;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err_d      = 1'b0;

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // rr_ptr names the port that wins a tie
          gnt_d   = (req0 && req1) ? rr_ptr : req1;
          we_d    = gnt_d ? we1    : we0;
          byte_d  = gnt_d ? byte1  : byte0;
          addr_d  = gnt_d ? addr1  : addr0;
          wdata_d = gnt_d ? wdata1 : wdata0;
          errf_d  = 1'b0;
          pcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pcnt == PW'(ADDR_SETUP - 1)) begin
          pcnt_d  = '0;
          state_d = S_SYNC;
        end else begin
          pcnt_d = pcnt + PW'(1);
        end
      end
      S_SYNC: begin
        pcnt_d  = '0;
        state_d = cur_we ? S_DSET : S_STRB;
      end
      S_DSET: begin
        if (pcnt == PW'(DATA_SETUP - 1)) begin
          pcnt_d  = '0;
          state_d = S_STRB;
        end else begin
          pcnt_d = pcnt + PW'(1);
        end
      end
      S_STRB: begin
        tcnt_d  = '0;
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        tcnt_d = (tcnt == TMAX) ? tcnt : tcnt + TW'(1);
        if (!nRPLY_i && !rply_q) begin
          if (!cur_we) rdata_d = ~nAD_i;
          state_d = S_REND;
        end else if (tcnt >= TW'(TIMEOUT - 2)) begin
          // STRB cycle plus tcnt+1 wait cycles: strobe has been low TIMEOUT cycles
          errf_d  = 1'b1;
          state_d = S_SREL;
        end
      end
      S_REND: begin
        if (nRPLY_i && rply_q) state_d = S_SREL;
      end
      S_SREL: state_d = S_DONE;
      S_DONE: begin
        rr_d    = ~gnt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_ADDR, S_SYNC: begin
        nbsy_d    = 1'b0;
        ctrl_oe_d = 1'b1;
        nad_oe_d  = 1'b1;
        nad_d     = ~addr_d;
        nwtbt_d   = ~we_d;
        if (state_d == S_SYNC) begin
          nsync_oe_d = 1'b1;
          nsync_d    = 1'b0;
        end
      end
      S_DSET, S_STRB, S_RWAIT, S_REND: begin
        nbsy_d     = 1'b0;
        ctrl_oe_d  = 1'b1;
        nsync_oe_d = 1'b1;
        nsync_d    = 1'b0;
        if (we_d) begin
          nad_oe_d = 1'b1;
          nad_d    = ~wdata_d;
          nwtbt_d  = ~byte_d;
          ndout_d  = !(state_d inside {S_STRB, S_RWAIT});
        end else begin
          ndin_d   = !(state_d inside {S_STRB, S_RWAIT});
        end
      end
      S_SREL: nsync_oe_d = 1'b1;
      S_DONE: begin
        ack0_d = ~gnt_d;
        ack1_d = gnt_d;
        err_d  = errf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKp) begin
    if (RSTp) begin
      state     <= S_IDLE;
      pcnt      <= '0;
      tcnt      <= '0;
      rply_q    <= 1'b1;
      gnt       <= 1'b0;
      cur_we    <= 1'b0;
      cur_byte  <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      rr_ptr    <= 1'b0;
      err_flag  <= 1'b0;
      rdata     <= '0;
      nAD_o     <= 16'hFFFF;
      nAD_oe    <= 1'b0;
      nSYNC_o   <= 1'b1;
      nSYNC_oe  <= 1'b0;
      nDIN_o    <= 1'b1;
      nDOUT_o   <= 1'b1;
      nWTBT_o   <= 1'b1;
      ctrl_oe   <= 1'b0;
      nBSY_o    <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_d;
      pcnt      <= pcnt_d;
      tcnt      <= tcnt_d;
      rply_q    <= nRPLY_i;
      gnt       <= gnt_d;
      cur_we    <= we_d;
      cur_byte  <= byte_d;
      cur_addr  <= addr_d;
      cur_wdata <= wdata_d;
      rr_ptr    <= rr_d;
      err_flag  <= errf_d;
      rdata     <= rdata_d;
      nAD_o     <= nad_d;
      nAD_oe    <= nad_oe_d;
      nSYNC_o   <= nsync_d;
      nSYNC_oe  <= nsync_oe_d;
      nDIN_o    <= ndin_d;
      nDOUT_o   <= ndout_d;
      nWTBT_o   <= nwtbt_d;
      ctrl_oe   <= ctrl_oe_d;
      nBSY_o    <= nbsy_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      err       <= err_d;
    end
  end

endmodule
